// File: rtl/sram_bridge.sv
// Serves the fetch and data request ports from one asynchronous 32-bit SRAM, one access at a time.
// Data has priority over fetch. Every SRAM-facing output and both valids come straight from flops.
module sram_bridge #(
    parameter int ADDR_W    = 20,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_be,
    output logic [31:0]       data_rdata,
    output logic              data_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WREC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_data_q, owner_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              inst_valid_q, inst_valid_d;
    logic              data_valid_q, data_valid_d;

    logic inst_elig, data_elig;
    logic unused_addr_bits;

    // A request still high in its own completion cycle is not a new request.
    assign inst_elig = inst_req & ~inst_valid_q;
    assign data_elig = data_req & ~data_valid_q;
    assign stall     = inst_elig | data_elig;

    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                data_addr[31:ADDR_W+2], data_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        dq_o_d       = dq_o_q;
        dq_oe_d      = dq_oe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        be_n_d       = be_n_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (data_elig) begin
                    owner_data_d = 1'b1;
                    addr_d       = data_addr[ADDR_W+1:2];
                    if (data_we && data_be == 4'b0000) begin
                        state_d      = S_DONE;
                        data_valid_d = 1'b1;
                    end else if (data_we) begin
                        state_d = S_WRITE;
                        dq_o_d  = data_wdata;
                        dq_oe_d = 1'b1;
                        ce_n_d  = 1'b0;
                        we_n_d  = 1'b0;
                        be_n_d  = ~data_be;
                    end else begin
                        state_d = S_READ;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        be_n_d  = 4'b0000;
                    end
                end else if (inst_elig) begin
                    owner_data_d = 1'b0;
                    addr_d       = inst_addr[ADDR_W+1:2];
                    state_d      = S_READ;
                    ce_n_d       = 1'b0;
                    oe_n_d       = 1'b0;
                    be_n_d       = 4'b0000;
                end
            end
            S_READ: begin
                if (cnt_q == RD_LAST) begin
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    if (owner_data_q) begin
                        data_rdata_d = sram_dq_i;
                        data_valid_d = 1'b1;
                    end else begin
                        inst_rdata_d = sram_dq_i;
                        inst_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    // Strobes release here; dq_oe stays up one more cycle for data hold.
                    state_d = S_WREC;
                    ce_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WREC: begin
                state_d      = S_DONE;
                dq_oe_d      = 1'b0;
                data_valid_d = owner_data_q;
                inst_valid_d = ~owner_data_q;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_data_q <= 1'b0;
            addr_q       <= '0;
            dq_o_q       <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            be_n_q       <= 4'hF;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            dq_o_q       <= dq_o_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            be_n_q       <= be_n_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign inst_valid = inst_valid_q;
    assign data_rdata = data_rdata_q;
    assign data_valid = data_valid_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule
